obi_fifo_cut: RTL and testbench

//   Parametrised OBI pipeline buffer: configurable-depth FIFOs on the A and R channels

---
 rtl/obi_fifo_cut_if.sv | 17 +
 rtl/obi_fifo_cut.sv | 122 ++++++++++++
 tb/tb_obi_fifo_cut.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/obi_fifo_cut_if.sv
// obi_fifo_cut_if: OBI A/R channel bundle; mgr drives the request, sbr answers it
interface obi_fifo_cut_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req;
  logic          gnt;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic          err;
  modport mgr (output req, addr, we, wdata, rready, input gnt, rvalid, rdata, err);
  modport sbr (input req, addr, we, wdata, rready, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_fifo_cut.sv
// obi_fifo_cut: OBI pipeline cut with A/R FIFOs and an outstanding-transaction limiter
module obi_fifo_cut_fifo #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_data
);
  localparam int PW = D > 1 ? $clog2(D) : 1;
  localparam int CW = $clog2(D + 1);
  localparam logic [PW-1:0] Last = PW'(D - 1);
  localparam logic [CW-1:0] Full = CW'(D);
  logic [W-1:0]  r_mem [2**PW];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;
  assign o_full  = r_cnt == Full;
  assign o_empty = r_cnt == '0;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= i_data;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr == Last ? '0 : r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd == Last ? '0 : r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

module obi_fifo_cut #(
  parameter bit UseRReady = 1'b1,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int ADepth    = 2,
  parameter int RDepth    = 2,
  parameter int MaxTxn    = 4,
  parameter int CntW      = $clog2(MaxTxn + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  obi_fifo_cut_if.sbr     sbr_port,
  obi_fifo_cut_if.mgr     mgr_port,
  output logic [CntW-1:0] outstanding_o,
  output logic            r_overflow_o
);
  localparam int ATW = AW + 1 + DW;
  localparam int RTW = DW + 1;
  // Without rready the R FIFO must be able to absorb every outstanding response
  localparam int LimI = (UseRReady || RDepth == 0) ? MaxTxn : (MaxTxn < RDepth ? MaxTxn : RDepth);
  localparam logic [CntW-1:0] Lim = CntW'(LimI);
  logic [CntW-1:0] r_cnt;
  logic            w_credit, w_inc, w_dec;
  assign w_credit      = r_cnt < Lim;
  assign w_inc         = mgr_port.req && mgr_port.gnt;
  assign w_dec         = sbr_port.rvalid && (!UseRReady || sbr_port.rready);
  assign outstanding_o = rst_i ? '0 : r_cnt;
  always_ff @(posedge clk_i)
    if (rst_i) r_cnt <= '0;
    else if (w_inc && !w_dec) r_cnt <= r_cnt + CntW'(1);
    else if (w_dec && !w_inc && r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
  if (ADepth == 0) begin : g_a_bypass
    assign sbr_port.gnt = !rst_i && mgr_port.gnt && w_credit;
    assign mgr_port.req = !rst_i && sbr_port.req && w_credit;
    assign {mgr_port.addr, mgr_port.we, mgr_port.wdata} = {sbr_port.addr, sbr_port.we, sbr_port.wdata};
  end else begin : g_a_fifo
    logic           w_full, w_empty;
    logic [ATW-1:0] w_head;
    obi_fifo_cut_fifo #(.W(ATW), .D(ADepth)) u_fifo (
      .clk_i,
      .rst_i,
      .i_push (sbr_port.req && sbr_port.gnt),
      .i_data ({sbr_port.addr, sbr_port.we, sbr_port.wdata}),
      .i_pop  (w_inc),
      .o_full (w_full),
      .o_empty(w_empty),
      .o_data (w_head)
    );
    assign sbr_port.gnt = !rst_i && !w_full;
    assign mgr_port.req = !rst_i && !w_empty && w_credit;
    assign {mgr_port.addr, mgr_port.we, mgr_port.wdata} = w_head;
  end
  if (RDepth == 0) begin : g_r_bypass
    assign mgr_port.rready = !rst_i && (!UseRReady || sbr_port.rready);
    assign sbr_port.rvalid = !rst_i && mgr_port.rvalid;
    assign {sbr_port.rdata, sbr_port.err} = {mgr_port.rdata, mgr_port.err};
    assign r_overflow_o = 1'b0;
  end else begin : g_r_fifo
    logic           w_full, w_empty, r_ovf;
    logic [RTW-1:0] w_head;
    obi_fifo_cut_fifo #(.W(RTW), .D(RDepth)) u_fifo (
      .clk_i,
      .rst_i,
      .i_push (mgr_port.rvalid && mgr_port.rready),
      .i_data ({mgr_port.rdata, mgr_port.err}),
      .i_pop  (w_dec),
      .o_full (w_full),
      .o_empty(w_empty),
      .o_data (w_head)
    );
    assign mgr_port.rready = !rst_i && (!UseRReady || !w_full);
    assign sbr_port.rvalid = !rst_i && !w_empty;
    assign {sbr_port.rdata, sbr_port.err} = w_head;
    assign r_overflow_o = r_ovf;
    // Only a subordinate ignoring the credit limit can hit a full FIFO here
    always_ff @(posedge clk_i)
      if (rst_i) r_ovf <= 1'b0;
      else if (!UseRReady && mgr_port.rvalid && w_full) r_ovf <= 1'b1;
  end
endmodule

// File: tb/tb_obi_fifo_cut.sv
// tb_obi_fifo_cut: directed checks of buffering, credit limiting, reset and bypass
module tb_obi_fifo_cut;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] o0, o3;
  logic [0:0] o6;
  logic       v0, v3, v6;
  int         total = 0;
  int         bad = 0;
  int         iss = 0;
  int         rcv = 0;
  int         b, g3;
  logic [7:0] sq[$];
  always #5 clk = ~clk;
  obi_fifo_cut_if #(.AW(8), .DW(8)) s0 (), m0 (), s3 (), m3 (), s6 (), m6 ();
  obi_fifo_cut #(.UseRReady(1'b1), .AW(8), .DW(8), .ADepth(2), .RDepth(2), .MaxTxn(4)) u0 (
    .clk_i(clk), .rst_i(rst), .sbr_port(s0), .mgr_port(m0), .outstanding_o(o0), .r_overflow_o(v0));
  obi_fifo_cut #(.UseRReady(1'b0), .AW(8), .DW(8), .ADepth(2), .RDepth(2), .MaxTxn(4)) u3 (
    .clk_i(clk), .rst_i(rst), .sbr_port(s3), .mgr_port(m3), .outstanding_o(o3), .r_overflow_o(v3));
  obi_fifo_cut #(.UseRReady(1'b1), .AW(8), .DW(8), .ADepth(0), .RDepth(0), .MaxTxn(1)) u6 (
    .clk_i(clk), .rst_i(rst), .sbr_port(s6), .mgr_port(m6), .outstanding_o(o6), .r_overflow_o(v6));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // u0 traffic: sbr issues incrementing addresses, subordinate answers rdata=addr one cycle after gnt
  task automatic run0(input int cycles, input int req_until, input int stall, input bit want_gnt);
    for (int c = 0; c < cycles; c++) begin
      s0.req    = c < req_until;
      s0.addr   = 8'(iss);
      s0.rready = c >= stall;
      m0.rvalid = sq.size() > 0;
      m0.rdata  = sq.size() > 0 ? sq[0] : 8'h00;
      #1;
      if (want_gnt && s0.req) chk("t2_sbr_gnt", s0.gnt, 1);
      if (s0.rvalid && s0.rready) begin
        chk("rdata_order", s0.rdata, 32'(8'(rcv)));
        rcv++;
      end
      if (m0.rvalid && m0.rready) void'(sq.pop_front());
      if (m0.req && m0.gnt) sq.push_back(m0.addr);
      if (s0.req && s0.gnt) iss++;
      tick();
    end
    s0.req    = 1'b0;
    s0.rready = 1'b1;
    m0.rvalid = 1'b0;
  endtask
  initial begin
    {s0.req, s0.addr, s0.we, s0.wdata, s0.rready} = '0;
    {s3.req, s3.addr, s3.we, s3.wdata, s3.rready} = '0;
    {s6.req, s6.addr, s6.we, s6.wdata, s6.rready} = '0;
    {m0.gnt, m0.rvalid, m0.rdata, m0.err} = '0;
    {m3.gnt, m3.rvalid, m3.rdata, m3.err} = '0;
    {m6.gnt, m6.rvalid, m6.rdata, m6.err} = '0;
    s0.req = 1'b1;
    s6.req = 1'b1;
    m6.gnt = 1'b1;
    tick();
    tick();
    chk("rst_sbr_gnt", s0.gnt, 0);
    chk("rst_mgr_req", m0.req, 0);
    chk("rst_mgr_rready", m0.rready, 0);
    chk("rst_sbr_rvalid", s0.rvalid, 0);
    chk("rst_outstanding", o0, 0);
    chk("rst_bypass_gnt", s6.gnt, 0);
    chk("rst_bypass_req", m6.req, 0);
    {s0.req, s6.req, m6.gnt} = '0;
    rst = 1'b0;
    tick();
    // single read through both FIFOs
    s0.req = 1'b1; s0.addr = 8'h10; m0.gnt = 1'b1; s0.rready = 1'b1;
    #1;
    chk("t1_sbr_gnt", s0.gnt, 1);
    chk("t1_mgr_req_early", m0.req, 0);
    tick();
    s0.req = 1'b0;
    #1;
    chk("t1_mgr_req", m0.req, 1);
    chk("t1_mgr_addr", m0.addr, 8'h10);
    chk("t1_cnt0", o0, 0);
    tick();
    m0.rvalid = 1'b1; m0.rdata = 8'hA5;
    #1;
    chk("t1_mgr_req_done", m0.req, 0);
    chk("t1_cnt1", o0, 1);
    chk("t1_mgr_rready", m0.rready, 1);
    chk("t1_sbr_rvalid_early", s0.rvalid, 0);
    tick();
    m0.rvalid = 1'b0;
    #1;
    chk("t1_sbr_rvalid", s0.rvalid, 1);
    chk("t1_sbr_rdata", s0.rdata, 8'hA5);
    chk("t1_cnt_hold", o0, 1);
    tick();
    chk("t1_sbr_rvalid_done", s0.rvalid, 0);
    chk("t1_cnt_back", o0, 0);
    // back-to-back burst of 8
    run0(16, 8, 0, 1);
    chk("t2_issued", iss, 8);
    chk("t2_received", rcv, 8);
    chk("t2_cnt", o0, 0);
    // rready stall: 4 outstanding + 2 buffered in the A FIFO
    b = iss;
    run0(20, 20, 20, 0);
    #1;
    chk("t4_issued", iss - b, 6);
    chk("t4_mgr_rready", m0.rready, 0);
    chk("t4_cnt_sat", o0, 4);
    chk("t4_sbr_gnt", s0.gnt, 0);
    chk("t4_mgr_req", m0.req, 0);
    run0(20, 0, 0, 0);
    chk("t4_drained", rcv, iss);
    chk("t4_cnt", o0, 0);
    // reset with both FIFOs holding entries
    run0(10, 10, 10, 0);
    rst = 1'b1;
    #1;
    chk("t5_sbr_gnt", s0.gnt, 0);
    chk("t5_sbr_rvalid", s0.rvalid, 0);
    chk("t5_mgr_req", m0.req, 0);
    chk("t5_mgr_rready", m0.rready, 0);
    chk("t5_cnt", o0, 0);
    tick();
    rst = 1'b0;
    sq.delete();
    #1;
    chk("t5_post_rvalid", s0.rvalid, 0);
    chk("t5_post_req", m0.req, 0);
    chk("t5_post_cnt", o0, 0);
    chk("t5_post_gnt", s0.gnt, 1);
    iss = 64;
    rcv = 64;
    run0(8, 1, 0, 0);
    chk("t5_new_issued", iss, 65);
    chk("t5_new_received", rcv, 65);
    chk("t5_new_cnt", o0, 0);
    chk("t5_overflow", v0, 0);
    // no rready: limit is RDepth=2
    g3 = 0;
    s3.req = 1'b1; m3.gnt = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m3.req && m3.gnt) g3++;
      if (o3 == 3'd2) chk("t3_req_low", m3.req, 0);
      tick();
    end
    s3.req = 1'b0;
    chk("t3_grants", g3, 2);
    chk("t3_cnt", o3, 2);
    chk("t3_sbr_gnt", s3.gnt, 0);
    chk("t3_mgr_rready", m3.rready, 1);
    m3.rvalid = 1'b1; m3.rdata = 8'h00;
    tick();
    m3.rdata = 8'h01;
    #1;
    chk("t3_rvalid0", s3.rvalid, 1);
    chk("t3_rdata0", s3.rdata, 8'h00);
    tick();
    m3.rvalid = 1'b0;
    #1;
    chk("t3_rdata1", s3.rdata, 8'h01);
    chk("t3_cnt_dec", o3, 1);
    chk("t3_req_back", m3.req, 1);
    m3.gnt = 1'b0;
    chk("t3_overflow", v3, 0);
    // zero-depth bypass throttled to one outstanding
    s6.req = 1'b1; s6.addr = 8'h33; m6.gnt = 1'b1; s6.rready = 1'b1;
    #1;
    chk("t6_sbr_gnt", s6.gnt, 1);
    chk("t6_mgr_req", m6.req, 1);
    chk("t6_mgr_addr", m6.addr, 8'h33);
    tick();
    s6.addr = 8'h34;
    m6.rvalid = 1'b1; m6.rdata = 8'h77;
    #1;
    chk("t6_cnt1", o6, 1);
    chk("t6_throttle_req", m6.req, 0);
    chk("t6_throttle_gnt", s6.gnt, 0);
    chk("t6_rvalid", s6.rvalid, 1);
    chk("t6_rdata", s6.rdata, 8'h77);
    chk("t6_rready", m6.rready, 1);
    tick();
    m6.rvalid = 1'b0;
    s6.rready = 1'b0;
    #1;
    chk("t6_cnt0", o6, 0);
    chk("t6_req_again", m6.req, 1);
    chk("t6_gnt_again", s6.gnt, 1);
    chk("t6_rready_pass", m6.rready, 0);
    chk("t6_overflow", v6, 0);
    s6.req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
